// File: rtl/hybrid_pwm_sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hybrid_pwm_sd_pkg                                         |
// | Purpose  : Shared constants and arithmetic helpers for the hybrid    |
// |            PWM / sigma-delta DAC.                                    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package hybrid_pwm_sd_pkg;

  // Default geometry: 16-bit samples, 32-clock frames
  localparam int DEF_DIN_W = 16;
  localparam int DEF_PWM_W = 5;
  localparam int F         = 1 << DEF_PWM_W;
  localparam int SUM_W     = DEF_PWM_W + DEF_DIN_W;
  localparam int MID       = 1 << (DEF_DIN_W - 1);

  // Two's complement -> offset binary is a flip of the sample MSB
  function automatic logic [63:0] to_offset(input logic [63:0] x,
                                            input int din_w,
                                            input bit signed_in);
    logic [63:0] flip;
    flip = 64'd1 << (din_w - 1);
    return signed_in ? (x ^ flip) : x;
  endfunction

  // Quantiser sum: 2^DIN_W + s*(F-2) + r. The 2^DIN_W term guarantees a
  // pulse of at least one clock; the (F-2) scale keeps it below F.
  function automatic logic [63:0] scale_sum(input logic [63:0] s,
                                            input logic [63:0] r,
                                            input int din_w,
                                            input int pwm_w);
    return (64'd1 << din_w) + s * ((64'd1 << pwm_w) - 64'd2) + r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hybrid_pwm_sd_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hybrid_pwm_sd_multi_if                                    |
// | Purpose  : Per-channel sample handshake bus (samples, valid, ready,  |
// |            mute) between the mixer and the DAC.                      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface hybrid_pwm_sd_multi_if #(
  parameter int CHANNELS = 2,
  parameter int DIN_W    = 16
);
  logic [CHANNELS*DIN_W-1:0] din;
  logic [CHANNELS-1:0]       din_valid;
  logic [CHANNELS-1:0]       din_ready;
  logic [CHANNELS-1:0]       mute;

  modport master (output din, output din_valid, output mute, input din_ready);
  modport slave  (input din, input din_valid, input mute, output din_ready);
endinterface
`default_nettype wire

// File: rtl/hybrid_pwm_sd_multi_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hybrid_pwm_sd_chan                                        |
// | Purpose  : One DAC channel: sample holding register, first-order     |
// |            sigma-delta width quantiser and PWM output flop.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hybrid_pwm_sd_chan
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int DIN_W     = DEF_DIN_W,
  parameter int PWM_W     = DEF_PWM_W,
  parameter int SIGNED_IN = 0
) (
  input  wire logic             clk,
  input  wire logic             n_reset,
  input  wire logic [PWM_W-1:0] cnt,
  input  wire logic             frame_edge,
  input  wire logic [DIN_W-1:0] din,
  input  wire logic             din_valid,
  input  wire logic             mute,
  output logic                  din_ready,
  output logic                  dout
);

  localparam int                 c_SUM_W   = PWM_W + DIN_W;
  localparam logic [DIN_W-1:0]   c_MID     = {1'b1, {(DIN_W-1){1'b0}}};
  localparam logic [PWM_W-1:0]   c_THR_RST = {1'b1, {(PWM_W-1){1'b0}}};

  logic [DIN_W-1:0]   r_holding;
  logic               r_pending;
  logic [DIN_W-1:0]   r_u;
  logic [PWM_W-1:0]   r_thr;
  logic [DIN_W-1:0]   r_res;
  logic               r_dout;

  logic               w_accept;
  logic [DIN_W-1:0]   w_conv;
  logic [DIN_W-1:0]   w_s;
  logic [c_SUM_W-1:0] w_sum;
  logic [PWM_W-1:0]   w_cnt_next;

  assign din_ready  = !r_pending;
  assign dout       = r_dout;
  assign w_accept   = din_valid && !r_pending;
  assign w_conv     = DIN_W'(to_offset(64'(din), DIN_W, SIGNED_IN != 0));
  assign w_cnt_next = cnt + PWM_W'(1);

  // Sample for the coming frame: mute overrides, a pending sample wins over u
  always_comb begin
    w_s = r_u;
    if (mute)
      w_s = c_MID;
    else if (r_pending)
      w_s = r_holding;
  end

  // Sum cannot exceed F*2^DIN_W - 1, so truncation to c_SUM_W is lossless
  assign w_sum = c_SUM_W'(scale_sum(64'(w_s), 64'(r_res), DIN_W, PWM_W));

  // Handshake, quantiser state and PWM output; new width loads at frame end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_holding <= '0;
      r_pending <= 1'b0;
      r_u       <= c_MID;
      r_thr     <= c_THR_RST;
      r_res     <= c_MID;
      r_dout    <= 1'b0;
    end else if (frame_edge) begin
      if (r_pending)
        r_u <= r_holding;
      // An accept here only happens with pending clear; it targets the next frame
      r_pending <= w_accept;
      if (w_accept)
        r_holding <= w_conv;
      r_thr  <= w_sum[c_SUM_W-1:DIN_W];
      r_res  <= w_sum[DIN_W-1:0];
      r_dout <= 1'b1;
    end else begin
      if (w_accept) begin
        r_holding <= w_conv;
        r_pending <= 1'b1;
      end
      if (w_cnt_next == r_thr)
        r_dout <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hybrid_pwm_sd_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hybrid_pwm_sd_multi                                       |
// | Purpose  : Multi-channel hybrid PWM / sigma-delta audio DAC. Owns    |
// |            the shared frame counter so all channels stay in phase.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hybrid_pwm_sd_multi
  import hybrid_pwm_sd_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIN_W     = DEF_DIN_W,
  parameter int PWM_W     = DEF_PWM_W,
  parameter int SIGNED_IN = 0
) (
  input  wire logic            clk,
  input  wire logic            n_reset,
  hybrid_pwm_sd_multi_if.slave bus,
  output logic [CHANNELS-1:0]  dout,
  output logic                 frame_end
);

  localparam logic [PWM_W-1:0] c_LAST = '1;

  logic [PWM_W-1:0]    r_cnt;
  logic                r_frame_end;
  logic                w_frame_edge;
  logic [CHANNELS-1:0] w_ready;
  logic [CHANNELS-1:0] w_dout;

  assign w_frame_edge  = (r_cnt == c_LAST);
  assign frame_end     = r_frame_end;
  assign bus.din_ready = w_ready;
  assign dout          = w_dout;

  // Free-running frame counter and one-cycle frame-end strobe
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt       <= '0;
      r_frame_end <= 1'b0;
    end else begin
      r_cnt       <= r_cnt + PWM_W'(1);
      r_frame_end <= w_frame_edge;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    hybrid_pwm_sd_chan #(
      .DIN_W     (DIN_W),
      .PWM_W     (PWM_W),
      .SIGNED_IN (SIGNED_IN)
    ) u_chan (
      .clk        (clk),
      .n_reset    (n_reset),
      .cnt        (r_cnt),
      .frame_edge (w_frame_edge),
      .din        (bus.din[c*DIN_W +: DIN_W]),
      .din_valid  (bus.din_valid[c]),
      .mute       (bus.mute[c]),
      .din_ready  (w_ready[c]),
      .dout       (w_dout[c])
    );
  end

endmodule
`default_nettype wire

// File: doc/hybrid_pwm_sd_multi.md
# hybrid_pwm_sd_multi

Multi-channel hybrid PWM / sigma-delta audio DAC. Each frame is a fixed-period PWM pulse whose width is chosen by a first-order sigma-delta quantiser of the input sample, so residual error is spread across frames. Samples enter through a per-channel valid/ready handshake into a holding register and take effect at the next frame boundary. The block sits between the sound mixer and the 1-bit audio pins; all channels share one frame counter and stay phase-locked.

## Interface
- CHANNELS, 2: number of independent output channels (≥1).
- DIN_W, 16: sample width.
- PWM_W, 5: PWM counter width; frame length F = 2^PWM_W clocks (PWM_W ≥ 2).
- SIGNED_IN, 0: 1 = din is two's complement, converted to offset binary by inverting its MSB.
- clk  in  1  system clock.
- n_reset  in  1  reset, asynchronous, active-low; clock clk.
- din  in  CHANNELS*DIN_W  samples; channel c occupies bits [c*DIN_W +: DIN_W].
- din_valid  in  CHANNELS  per-channel sample valid.
- din_ready  out  CHANNELS  per-channel ready; equals !pending[c].
- mute  in  CHANNELS  per-channel mute; substitutes midscale, sampled at the frame-end edge.
- dout  out  CHANNELS  registered 1-bit PWM outputs.
- frame_end  out  1  registered, high for one cycle after each frame-end edge.

## Operation
- Shared counter cnt, PWM_W bits, increments every clock and wraps from F-1 to 0. The frame-end edge is the edge where cnt == F-1.
- Per channel: holding register, pending flag, active sample u (offset binary, DIN_W bits), threshold thr (PWM_W bits), residual r (DIN_W bits).
- Accept: on the edge where din_valid[c] && din_ready[c], the converted sample is stored in holding and pending is set.
- Frame-end edge, per channel:
  - s = midscale (2^(DIN_W-1)) if mute[c], else holding if pending, else u.
  - u <= holding if pending. Mute does not discard holding.
  - pending <= 0, unless an accept occurs on the same edge. An accept here is only possible when pending was already 0, so the new sample is for the next frame.
  - sum = 2^DIN_W + s*(F-2) + r, computed at width PWM_W+DIN_W. It cannot overflow.
  - thr <= sum[PWM_W+DIN_W-1 : DIN_W], range 1..F-1. r <= sum[DIN_W-1:0].
  - dout <= 1.
- Other edges: dout <= 0 on the edge where cnt+1 == thr (new thr); otherwise dout holds.
- Result: dout is high for exactly thr clocks per frame, never 0 or F. The long-run mean width is 1 + s*(F-2)/2^DIN_W.

## Timing
- Reset values: cnt=0, dout=0, frame_end=0, pending=0 (so din_ready=1), u=2^(DIN_W-1), thr=2^(PWM_W-1), r=2^(DIN_W-1).
- After reset, dout stays 0 until the first frame-end edge, F clocks after release.
- Latency: a sample accepted at an edge with cnt=k drives the pulse starting at the next frame-end edge, which is F-1-k clocks later. k = F-1 defers it one full frame.
- Back-pressure: at most one sample per channel per frame. din_ready falls the cycle after an accept and rises the cycle after the frame-end edge.
- Reset mid-frame clears all state immediately and discards pending samples.

## Structure
- Shared package `hybrid_pwm_sd_pkg`:
  - localparams F, SUM_W = PWM_W+DIN_W, MID = 2^(DIN_W-1).
  - Function for offset-binary conversion.
  - Function for the sum scaling.
- Sub-module `hybrid_pwm_sd_chan`, instantiated CHANNELS times. It holds holding/pending/u/thr/r/dout and takes cnt and the frame-end strobe from the top.
- The top owns cnt and frame_end.

## Test plan
All cases use DIN_W=16, PWM_W=5, F=32.
- Reset then no writes → every frame after the first has dout high 16 clocks, low 16. din_ready=1.
- Write u=0x0000 once → the following frames each show a 1-clock pulse. Residual stays 32768.
- Write u=0x8000 → thr=16 every frame. Assert mute instead → identical waveform. Release mute → the held sample resumes.
- Write u=0x4000 → thr alternates 9, 8, 9, 8… (sum = 8.5·65536 + r).
- Write u=0xFFFF → thr is 31 or 32-clamped-free: dout is low exactly 1 clock per frame in almost all frames, and low ≥1 clock in every frame. With SIGNED_IN=1, din=0x0000 gives the 16/16 waveform.
- Handshake, CHANNELS=2, valid held high:
  - exactly one accept per channel per frame;
  - a write at cnt=31 takes effect one frame later;
  - independent channels do not interfere;
  - n_reset asserted mid-frame → outputs return to reset values at once.
